// File: rtl/div_ctrl.sv
// div_ctrl -- multi-cycle 32-bit DIV/DIVU controller for the EX stage.
//
// A restoring shift-subtract divider runs over 32 cycles. The pipeline is
// stalled while the division is in flight. The result is presented for one
// cycle on the hi/lo write bus.
//
// Optional feature: define DIV_ZERO_FAST_EN to short-cut a zero divisor through
// the BYZERO state, so the result appears two cycles after launch. With the
// macro undefined, a zero divisor runs the full 32 RUN cycles. The result
// values are identical in both builds.
`timescale 1ns/1ps

module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        annul_i,
    output logic        stallreq_o,
    output logic        ready_o,
    output logic [65:0] hl_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [5:0] LAST_STEP = 6'd31;

    // Two's-complement negation of a 32-bit word.
    function automatic logic [31:0] f_neg(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // Magnitude of an operand. The operand is only treated as signed for DIV.
    // 0x80000000 maps onto itself, and that is still the correct unsigned
    // magnitude.
    function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
        logic [31:0] res;
        if (is_signed && v[31]) begin
            res = f_neg(v);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // FSM and counter
    logic [1:0]  r_state;
    logic [5:0]  r_cnt;

    // Datapath registers
    logic [31:0] r_rem;        // partial remainder (magnitude)
    logic [31:0] r_quo;        // dividend bits shifting out, quotient bits shifting in
    logic [31:0] r_dvs;        // divisor magnitude
    logic        r_neg_q;      // quotient must be negated at the end
    logic        r_neg_r;      // remainder takes the (negative) sign of the dividend
    logic        r_zero;       // divisor was zero at launch
    logic [31:0] r_raw;        // raw dividend, returned as hi on divide-by-zero

    // Combinational helpers
    logic [1:0]  w_next;
    logic        w_launch;
    logic        w_dvs_zero;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_lo;
    logic [31:0] w_hi;

    assign w_dvs_zero = (divisor_i == 32'd0);

    // Next-state selection; annul_i overrides every transition and blocks launch
    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    w_launch = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    if (w_dvs_zero) begin
                        w_next = S_BYZERO;
                    end else begin
                        w_next = S_RUN;
                    end
`else
                    w_next = S_RUN;
`endif
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BYZERO: begin
`ifdef DIV_ZERO_FAST_EN
                if (annul_i) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
`else
                // Unreachable in this build; recover to IDLE.
                w_next = S_IDLE;
`endif
            end
            S_RUN: begin
                if (annul_i) begin
                    w_next = S_IDLE;
                end else if (r_cnt == LAST_STEP) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_DONE: begin
                // Never relaunches from DONE, even with start_i still high.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        w_shift = {r_rem, r_quo[31]};
        w_ge    = (w_shift >= {1'b0, r_dvs});
        if (w_ge) begin
            // The difference is below the divisor, so it fits in 32 bits.
            w_rem_nxt = w_shift[31:0] - r_dvs;
        end else begin
            w_rem_nxt = w_shift[31:0];
        end
        w_quo_nxt = {r_quo[30:0], w_ge};
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_dvs   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
            r_raw   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_cnt   <= 6'd0;
                r_rem   <= 32'd0;
                r_quo   <= f_mag(dividend_i, signed_i);
                r_dvs   <= f_mag(divisor_i, signed_i);
                r_neg_q <= signed_i & (dividend_i[31] ^ divisor_i[31]);
                r_neg_r <= signed_i & dividend_i[31];
                r_zero  <= w_dvs_zero;
                r_raw   <= dividend_i;
            end else if (r_state == S_RUN) begin
                r_cnt   <= r_cnt + 6'd1;
                r_rem   <= w_rem_nxt;
                r_quo   <= w_quo_nxt;
            end else begin
                r_cnt   <= r_cnt;
                r_rem   <= r_rem;
                r_quo   <= r_quo;
            end
        end
    end

    // Final sign fix-up, plus the fixed divide-by-zero result
    always_comb begin
        if (r_zero) begin
            w_lo = 32'hFFFF_FFFF;
            w_hi = r_raw;
        end else begin
            if (r_neg_q) begin
                w_lo = f_neg(r_quo);
            end else begin
                w_lo = r_quo;
            end
            if (r_neg_r) begin
                w_hi = f_neg(r_rem);
            end else begin
                w_hi = r_rem;
            end
        end
    end

    // Output decode from the state register; hl_o is non-zero only in DONE
    always_comb begin
        stallreq_o = 1'b0;
        ready_o    = 1'b0;
        hl_o       = 66'd0;
        case (r_state)
            S_IDLE: begin
                stallreq_o = start_i;
            end
            S_BYZERO: begin
                stallreq_o = 1'b1;
            end
            S_RUN: begin
                stallreq_o = 1'b1;
            end
            S_DONE: begin
                ready_o = 1'b1;
                hl_o    = {1'b1, 1'b1, w_hi, w_lo};
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 The ports SHALL be:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start_i, in, 1: EX-stage DIV/DIVU present; held stable while stallreq_o=1.
- signed_i, in, 1: 1 = DIV, 0 = DIVU; sampled with start_i.
- dividend_i, in, 32: rs operand; sampled with start_i.
- divisor_i, in, 32: rt operand; sampled with start_i.
- annul_i, in, 1: pipeline flush; cancels any operation.
- stallreq_o, out, 1: request to stall IF..EX.
- ready_o, out, 1: result valid this cycle.
- hl_o, out, 66: {hi_we, lo_we, hi, lo}, same layout as the pipeline hi/lo bus.

Function
REQ-003 The FSM SHALL have four states: IDLE, BYZERO, RUN and DONE, and SHALL reset to IDLE.
REQ-004 IDLE transitions SHALL be:
- start_i=1, annul_i=0, divisor_i!=0: latch the operands, go to RUN, clear the 6-bit counter.
- divisor zero: go to BYZERO.
REQ-005 In the IDLE cycle that sees start_i=1, stallreq_o SHALL be 1 (combinational).
REQ-006 RUN SHALL perform one restoring shift-subtract step per cycle on 32-bit magnitudes and increment the counter.
REQ-007 RUN SHALL go to DONE after exactly 32 RUN cycles.
REQ-008 Signed operations SHALL:
- use absolute values of the operands at latch time;
- negate the quotient when the operand signs differ;
- give the remainder the sign of the dividend.
REQ-009 0x80000000 / 0xFFFFFFFF signed SHALL give lo=0x80000000 and hi=0, with no exception.
REQ-010 A zero divisor SHALL give lo=0xFFFFFFFF and hi=dividend_i (raw), for both signed and unsigned operations.
REQ-011 In DONE:
- ready_o=1, stallreq_o=0, hl_o={1,1,remainder,quotient};
- next state is IDLE unconditionally, so a start_i still high in DONE SHALL NOT relaunch.
REQ-012 In every state other than DONE, ready_o SHALL be 0 and hl_o SHALL be 66'b0.
REQ-013 stallreq_o SHALL be 1 in RUN and BYZERO.
REQ-014 Latency: with start_i at cycle 0, ready_o SHALL rise at cycle 33 and stallreq_o SHALL be high for cycles 0-32.
REQ-015 annul_i=1 SHALL force the next state to IDLE from any state, and SHALL also suppress a launch in the same cycle.
REQ-016 annul_i SHALL NOT mask the current-cycle ready_o/hl_o when the state is DONE.
REQ-017 Priority SHALL be rst > annul_i > normal sequencing.

Reset
REQ-018 On rst:
- state=IDLE, counter=0, all operand/partial registers=0;
- stallreq_o=0, ready_o=0, hl_o=66'b0 from the next cycle.
REQ-019 rst mid-RUN SHALL discard the operation, and no ready_o pulse SHALL follow.

Configuration
REQ-020 With macro DIV_ZERO_FAST_EN defined, a zero divisor SHALL route IDLE -> BYZERO -> DONE, giving ready_o at cycle 2.
REQ-021 Without DIV_ZERO_FAST_EN, BYZERO SHALL be unused and a zero divisor SHALL run the full 32 RUN cycles (ready_o at cycle 33).
REQ-022 Result values SHALL be identical (REQ-010) with and without DIV_ZERO_FAST_EN.

Verification
REQ-023 Unsigned 100/7, start at cycle 0: ready_o at cycle 33, hl_o={1,1,0x00000002,0x0000000E}, stallreq_o high cycles 0-32.
REQ-024 Signed -7/2 (0xFFFFFFF9/0x00000002): lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-025 Signed 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-026 Unsigned 0x1234/0:
- lo=0xFFFFFFFF, hi=0x00001234 in both cases;
- ready_o at cycle 2 with DIV_ZERO_FAST_EN, at cycle 33 without.
REQ-027 annul_i pulsed at cycle 10 of an operation: IDLE at cycle 11, stallreq_o=0 at cycle 11, no ready_o pulse; a new start at cycle 12 completes normally at cycle 45.
REQ-028 rst at cycle 20 mid-RUN: all outputs 0 at cycle 21, no ready_o through cycle 40 with start_i low.
